// File: rtl/vga_frame_checker.sv
// vga_frame_checker: receive-side monitor for a VGA stream. Recovers line and
// frame timing from hsync/vsync, checks it against the configured timing,
// flags sticky errors and produces a per-frame checksum of active pixels.
//
// state  | meaning
// HUNT   | no timing reference; wait for an hsync assertion edge
// ALIGN  | line timing seen; wait for the vsync-driven line reset
// LOCKED | timing recovered; checks, checksum and frame counting active
module vga_frame_checker #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rgb,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        clr_err,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic [7:0]  frame_count,
  output logic        h_err,
  output logic        v_err,
  output logic        blank_err
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PIX     = H_ACTIVE * V_ACTIVE;
  // One spare bit so a saturated count can never alias the expected total.
  localparam int PW      = $clog2(PIX + 1) + 1;

  localparam logic [10:0] POS_MAX  = 11'h7ff;
  localparam logic [10:0] H_ACT_LO = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_ACT_HI = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [10:0] V_ACT_LO = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_ACT_HI = 11'(V_SYNC + V_BP + V_ACTIVE - 1);

  typedef enum logic [1:0] {HUNT, ALIGN, LOCKED} state_t;

  state_t         state, state_nx;
  logic [DW-1:0]  div;
  logic           tick;
  logic           hs_q, vs_q;
  logic [10:0]    h_pos, line, h_pos_nx, line_nx;
  logic           pend;
  logic [15:0]    sum;
  logic [PW-1:0]  pix;

  logic hs_fall, hs_rise, vs_fall, vs_rise, line_rst, active;
  logic h_evt, v_evt, cnt_bad, b_evt, err_evt, close_ok, in_lock;

  assign tick    = (div == DW'(CLK_DIV - 1));
  assign locked  = (state == LOCKED);
  assign in_lock = (state == LOCKED);

  // Free-running pixel-tick divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div <= '0;
    else if (tick) div <= '0;
    else           div <= div + 1'b1;
  end

  // Edge detection, next positions, active-area decode and error events for this tick.
  always_comb begin
    hs_fall  = tick & hs_q & ~hsync;
    hs_rise  = tick & ~hs_q & hsync;
    vs_fall  = tick & vs_q & ~vsync;
    vs_rise  = tick & ~vs_q & vsync;
    line_rst = hs_fall & (pend | vs_fall);

    h_pos_nx = h_pos;
    if (hs_fall)                      h_pos_nx = '0;
    else if (tick && h_pos != POS_MAX) h_pos_nx = h_pos + 11'd1;

    line_nx = line;
    if (line_rst)                        line_nx = '0;
    else if (hs_fall && line != POS_MAX) line_nx = line + 11'd1;

    // h_pos_nx/line_nx are the coordinates of the pixel sampled on this tick.
    active = tick && (h_pos_nx >= H_ACT_LO) && (h_pos_nx <= H_ACT_HI) &&
             (line_nx >= V_ACT_LO) && (line_nx <= V_ACT_HI);

    h_evt = (hs_fall && (({1'b0, h_pos} + 12'd1) != 12'(H_TOTAL))) ||
            (hs_rise && (h_pos != 11'(H_SYNC - 1)));
    v_evt = (line_rst && (({1'b0, line} + 12'd1) != 12'(V_TOTAL))) ||
            (vs_rise && (line_nx != 11'(V_SYNC)));
    cnt_bad  = line_rst && (pix != PW'(PIX));
    b_evt    = tick && !active && (rgb != 8'd0);
    err_evt  = h_evt | v_evt | cnt_bad;
    close_ok = line_rst && !err_evt;
  end

  // Line/frame timing recovery, running in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      h_pos <= '0;
      line  <= '0;
      pend  <= 1'b0;
    end else if (tick) begin
      hs_q  <= hsync;
      vs_q  <= vsync;
      h_pos <= h_pos_nx;
      line  <= line_nx;
      if (line_rst)     pend <= 1'b0;
      else if (vs_fall) pend <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      HUNT:    if (hs_fall)  state_nx = ALIGN;
      ALIGN:   if (line_rst) state_nx = LOCKED;
      LOCKED:  if (err_evt)  state_nx = HUNT;
      default: state_nx = HUNT;
    endcase
  end

  // Running checksum and active pixel count; restarted at every frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
      pix <= '0;
    end else if ((state == ALIGN || state == LOCKED) && line_rst) begin
      sum <= '0;
      pix <= '0;
    end else if (in_lock && active) begin
      sum <= sum + {8'h00, rgb};
      if (pix != '1) pix <= pix + 1'b1;
    end
  end

  // Frame results and sticky error flags; a new error beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done  <= 1'b0;
      frame_sum   <= '0;
      frame_count <= '0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      blank_err   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (in_lock && close_ok) begin
        frame_done  <= 1'b1;
        frame_sum   <= sum;
        frame_count <= frame_count + 8'd1;
      end
      h_err     <= (h_err & ~clr_err) | (in_lock & h_evt);
      v_err     <= (v_err & ~clr_err) | (in_lock & (v_evt | cnt_bad));
      blank_err <= (blank_err & ~clr_err) | (in_lock & b_evt);
    end
  end

endmodule

// File: tb/tb_vga_frame_checker.sv
// Randomised frame-level bench for vga_frame_checker on a tiny 16x8 timing.
module tb_vga_frame_checker;
  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rgb = 8'd0;
  logic        hsync = 1'b1, vsync = 1'b1, clr_err = 1'b0;
  logic        locked, frame_done, h_err, v_err, blank_err;
  logic [15:0] frame_sum;
  logic [7:0]  frame_count;

  vga_frame_checker #(
    .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst), .rgb(rgb), .hsync(hsync), .vsync(vsync),
    .clr_err(clr_err), .locked(locked), .frame_done(frame_done),
    .frame_sum(frame_sum), .frame_count(frame_count),
    .h_err(h_err), .v_err(v_err), .blank_err(blank_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // expected frame results, pushed when a frame is closed by stimulus
  int exp_sum_q[$];
  int exp_cnt_q[$];

  // reference model: 0 = hunting, 1 = aligning, 2 = locked
  int m_state = 0;
  int m_sum = 0, m_pix = 0, m_count = 0;
  bit m_h = 0, m_v = 0, m_b = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // monitor: every frame_done must match the oldest expected frame result
  always @(negedge clk) begin
    if (!rst && frame_done) begin
      if (exp_sum_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame_done actual=1 required=0 count=%0d", frame_count);
      end else begin
        int s, c;
        s = exp_sum_q.pop_front();
        c = exp_cnt_q.pop_front();
        check("frame_sum", 32'(frame_sum), 32'(s));
        check("frame_count", 32'(frame_count), 32'(c));
      end
    end
  end

  task automatic model_reset();
    m_state = 0; m_sum = 0; m_pix = 0; m_count = 0;
    m_h = 0; m_v = 0; m_b = 0;
  endtask

  task automatic check_flags();
    check("locked", 32'(locked), 32'(m_state == 2));
    check("h_err", 32'(h_err), 32'(m_h));
    check("v_err", 32'(v_err), 32'(m_v));
    check("blank_err", 32'(blank_err), 32'(m_b));
  endtask

  task automatic check_all_zero(input string name);
    check(name, 32'({locked, frame_done, frame_sum, frame_count, h_err, v_err, blank_err}), 32'd0);
  endtask

  task automatic do_tick(input logic h, input logic v, input logic [7:0] r, input logic c);
    hsync = h; vsync = v; rgb = r; clr_err = c;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_tick(1'b1, 1'b1, 8'd0, 1'b0);
  endtask

  // mode: 0 ones, 1 pixel column, 2 random. bad: 0 none, 1 long line,
  // 2 wide hsync, 3 three-line vsync. glitch_line: nonzero rgb in front porch.
  task automatic send_frame(input int mode, input int bad, input int bad_line,
                            input int glitch_line, input bit clr_start,
                            input bit clr_glitch, input int rst_line);
    int vw, len, hsw;
    vw = (bad == 3) ? 3 : 2;
    for (int ln = 0; ln < VT; ln++) begin
      len = (bad == 1 && ln == bad_line) ? HT + 1 : HT;
      hsw = (bad == 2 && ln == bad_line) ? HS + 1 : HS;
      if (ln == 0) begin
        if (m_state == 2) begin
          if (m_pix == HA * VA) begin
            m_count = (m_count + 1) % 256;
            exp_sum_q.push_back(m_sum % 65536);
            exp_cnt_q.push_back(m_count);
          end else begin
            m_v = 1; m_state = 0;
          end
          m_sum = 0; m_pix = 0;
        end else if (m_state == 1) begin
          m_state = 2; m_sum = 0; m_pix = 0;
        end else begin
          m_state = 1;
        end
      end else if (m_state == 2 && ((bad == 1 && ln == bad_line + 1) || (bad == 3 && ln == vw))) begin
        if (bad == 1) m_h = 1; else m_v = 1;
        m_state = 0;
      end else if (m_state == 0) begin
        m_state = 1;
      end
      for (int p = 0; p < len; p++) begin
        bit act, c;
        logic [7:0] px;
        act = (p >= HS + HB) && (p < HS + HB + HA) && (ln >= VS + VB) && (ln < VS + VB + VA);
        px = 8'd0;
        if (act) begin
          case (mode)
            0:       px = 8'd1;
            1:       px = 8'(p);
            default: px = 8'($urandom_range(0, 255));
          endcase
        end
        c = 1'b0;
        if (clr_start && ln == 0 && p == 1) begin
          c = 1'b1; m_h = 0; m_v = 0; m_b = 0;
        end
        if (ln == glitch_line && p == HS + HB + HA) begin
          px = 8'h05;
          if (clr_glitch) begin c = 1'b1; m_h = 0; m_v = 0; m_b = 0; end
          if (m_state == 2) m_b = 1;
        end
        if (bad == 2 && ln == bad_line && p == hsw && m_state == 2) begin
          m_h = 1; m_state = 0;
        end
        if (act && m_state == 2) begin
          m_sum += int'(px); m_pix++;
        end
        if (ln == rst_line && p == 5) begin
          rst = 1'b1;
          #1;
          check_all_zero("async_reset_outputs");
          repeat (3) @(posedge clk);
          #1;
          check_all_zero("held_reset_outputs");
          rst = 1'b0;
          model_reset();
          return;
        end
        do_tick(p >= hsw, ln >= vw, px, c);
        if (ln == 0 && p == 0) check_flags();
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    rst = 1'b0;
    idle(4);

    // clean frames, constant and column-valued pixels
    for (int f = 0; f < 4; f++) send_frame(0, 0, 0, -1, 0, 0, -1);
    for (int f = 0; f < 3; f++) send_frame(1, 0, 0, -1, 0, 0, -1);
    // long line mid-frame, relock, then clear
    send_frame(0, 1, 2, -1, 0, 0, -1);
    send_frame(0, 0, 0, -1, 0, 0, -1);
    send_frame(1, 0, 0, -1, 1, 0, -1);
    send_frame(0, 0, 0, -1, 0, 0, -1);
    // front-porch glitch keeps lock; then glitch racing a clear
    send_frame(0, 0, 0, 4, 0, 0, -1);
    send_frame(2, 0, 0, 6, 0, 1, -1);
    send_frame(0, 0, 0, -1, 0, 0, -1);
    // wide vsync, wide hsync
    send_frame(1, 3, 0, -1, 1, 0, -1);
    send_frame(0, 0, 0, -1, 0, 0, -1);
    send_frame(2, 2, 3, -1, 0, 0, -1);
    send_frame(0, 0, 0, -1, 0, 0, -1);
    // randomised mix
    for (int f = 0; f < 24; f++) begin
      int r, bad, bl, gl, md;
      bit cs;
      r  = int'($urandom_range(0, 9));
      bad = (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 3 : 0;
      bl = int'($urandom_range(1, 5));
      gl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, VT - 1)) : -1;
      md = int'($urandom_range(0, 2));
      cs = ($urandom_range(0, 4) == 0);
      send_frame(md, bad, bl, gl, cs, 0, -1);
    end
    // reset mid-frame, then enough clean frames to wrap frame_count
    send_frame(0, 0, 0, -1, 0, 0, 4);
    idle(5);
    for (int f = 0; f < 258; f++) send_frame(int'($urandom_range(0, 2)), 0, 0, -1, 0, 0, -1);
    idle(6);
    check("pending_frame_done", 32'(exp_sum_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
